// File: rtl/ps2_tx_shiftreg.sv
// PS/2 host-to-device transmit shifter: loads an 11-bit frame and shifts it out LSB first on
// synchronized falling edges of the PS/2 clock; Q is registered, Done marks idle/frame complete.
module ps2_tx_shiftreg (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Write,
    input  logic [10:0] Data,
    input  logic        ShiftClk,
    input  logic        ShiftEn,
    output logic        Done,
    output logic        Q
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [10:0] r_sr;
    logic [10:0] w_sr_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_fall;
    logic        w_busy;
    logic        w_shift;

    // Sync flops idle high so a reset never fabricates a falling edge.
    assign w_fall  = r_s3 & ~r_s2;
    assign w_busy  = (r_state == ST_SHIFT);
    assign w_shift = w_fall & ShiftEn & w_busy;

    assign Done = (r_state == ST_IDLE);
    assign Q    = r_sr[0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s3    <= 1'b1;
            r_state <= ST_IDLE;
            r_sr    <= 11'h7FF;
            r_cnt   <= 4'd0;
        end else begin
            r_s1    <= ShiftClk;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A load always beats a coincident shift: the new frame starts clean.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        if (Write) begin
            w_sr_nxt    = Data;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_SHIFT;
        end else if (w_shift) begin
            w_sr_nxt  = {1'b1, r_sr[10:1]};
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd10) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx_shiftreg.sv
// Bench for ps2_tx_shiftreg: table of frame operations with model-derived expectations fed
// through a scoreboard queue, plus hand sequences for latency and collision cases.
module tb_ps2_tx_shiftreg;

    localparam int HALF_PH = 100;  // 1000 ns ShiftClk phase at 10 ns Clk

    logic        Clk;
    logic        Reset;
    logic        Write;
    logic [10:0] Data;
    logic        ShiftClk;
    logic        ShiftEn;
    logic        Done;
    logic        Q;

    ps2_tx_shiftreg dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Write    (Write),
        .Data     (Data),
        .ShiftClk (ShiftClk),
        .ShiftEn  (ShiftEn),
        .Done     (Done),
        .Q        (Q)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef enum logic [1:0] {OP_RST, OP_WR, OP_FALL} op_e;

    typedef struct {
        op_e         op;
        logic [10:0] data;
        logic        en;
        logic        exp_q;
        logic        exp_done;
        logic [3:0]  exp_cnt;
    } row_t;

    typedef struct {
        int          idx;
        logic        q;
        logic        done;
        logic [3:0]  cnt;
    } exp_t;

    row_t tbl[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [10:0] m_sr;
    logic [3:0]  m_cnt;
    logic        m_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input op_e op, input logic [10:0] data, input logic en);
        row_t r;
        case (op)
            OP_RST: begin
                m_sr = 11'h7FF; m_cnt = 4'd0; m_done = 1'b1;
            end
            OP_WR: begin
                m_sr = data; m_cnt = 4'd0; m_done = 1'b0;
            end
            default: begin
                if (en && !m_done) begin
                    m_sr  = {1'b1, m_sr[10:1]};
                    m_cnt = m_cnt + 4'd1;
                    if (m_cnt == 4'd11) m_done = 1'b1;
                end
            end
        endcase
        r.op = op; r.data = data; r.en = en;
        r.exp_q = m_sr[0]; r.exp_done = m_done; r.exp_cnt = m_cnt;
        tbl.push_back(r);
    endtask

    task automatic add_falls(input int n, input logic en);
        for (int i = 0; i < n; i++) add(OP_FALL, 11'h0, en);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_fall(input logic en);
        ShiftEn  = en;
        ShiftClk = 1'b0;
        ticks(HALF_PH);
        ShiftClk = 1'b1;
        ticks(HALF_PH);
    endtask

    task automatic do_write(input logic [10:0] d);
        Data  = d;
        Write = 1'b1;
        tick();
        Write = 1'b0;
        ticks(2);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        ticks(2);
    endtask

    initial begin
        exp_t e;

        Reset = 1'b1; Write = 1'b0; Data = 11'h0; ShiftClk = 1'b1; ShiftEn = 1'b1;

        // Table: idle toggling, full frame, gated frame, abort/reload, reset mid-frame.
        add(OP_RST, 11'h0, 1'b1);
        add_falls(3, 1'b1);
        add(OP_WR, 11'h7AE, 1'b1);
        add_falls(12, 1'b1);
        add(OP_WR, 11'h7AE, 1'b1);
        add_falls(4, 1'b1);
        add_falls(3, 1'b0);
        add_falls(7, 1'b1);
        add(OP_WR, 11'h7AE, 1'b1);
        add_falls(4, 1'b1);
        add(OP_WR, 11'h400, 1'b1);
        add_falls(11, 1'b1);
        add(OP_WR, 11'h7AE, 1'b1);
        add_falls(5, 1'b1);
        add(OP_RST, 11'h0, 1'b1);
        add_falls(2, 1'b1);

        tick();
        chk("reset_done", Done, 1'b1);
        chk("reset_q", Q, 1'b1);
        Reset = 1'b0;
        ticks(2);

        for (int i = 0; i < tbl.size(); i++) begin
            sb.push_back('{i, tbl[i].exp_q, tbl[i].exp_done, tbl[i].exp_cnt});
            case (tbl[i].op)
                OP_RST:  do_reset();
                OP_WR:   do_write(tbl[i].data);
                default: do_fall(tbl[i].en);
            endcase
            e = sb.pop_front();
            chk($sformatf("row%0d_q", e.idx), Q, e.q);
            chk($sformatf("row%0d_done", e.idx), Done, e.done);
            chk($sformatf("row%0d_cnt", e.idx), dut.r_cnt, e.cnt);
        end
        ShiftEn = 1'b1;

        // Reset wins over a simultaneous Write.
        Data = 11'h400; Write = 1'b1; Reset = 1'b1;
        tick();
        Write = 1'b0; Reset = 1'b0;
        chk("rst_vs_wr_done", Done, 1'b1);
        chk("rst_vs_wr_q", Q, 1'b1);
        ticks(2);

        // Write held for several cycles keeps the frame freshly loaded.
        Data = 11'h7AE; Write = 1'b1;
        ticks(3);
        Write = 1'b0;
        tick();
        chk("long_wr_done", Done, 1'b0);
        chk("long_wr_q", Q, 1'b0);
        chk("long_wr_cnt", dut.r_cnt, 4'd0);

        // Edge 1 samples ShiftClk low; Q moves on edge 3.
        ShiftClk = 1'b0;
        tick();
        chk("lat_e1_q", Q, 1'b0);
        tick();
        chk("lat_e2_q", Q, 1'b0);
        tick();
        chk("lat_e3_q", Q, 1'b1);
        chk("lat_e3_cnt", dut.r_cnt, 4'd1);
        ShiftClk = 1'b1;
        ticks(10);

        // Write coinciding with a shift event: reload wins, shift discarded.
        ShiftClk = 1'b0;
        ticks(2);
        Data = 11'h555; Write = 1'b1;
        tick();
        Write = 1'b0;
        chk("coll_sr", dut.r_sr, 11'h555);
        chk("coll_cnt", dut.r_cnt, 4'd0);
        chk("coll_q", Q, 1'b1);
        ShiftClk = 1'b1;
        ticks(10);
        chk("coll_no_defer_sr", dut.r_sr, 11'h555);
        chk("coll_done", Done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
